iomem_uart: RTL

//  Memory-mapped hardware UART on the picorv32 iomem bus. Drives pin_tx, receives pin_rx
//  (the physical serial pins, independent of the USB UART). Sits between the top-level

---
 rtl/iomem_uart_if.sv | 21 ++
 rtl/iomem_uart.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_uart_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : iomem_uart_if                                           |
// | Description : picorv32 iomem bus slice seen by the hardware UART.     |
// |               Master = address decoder / CPU side, slave = UART.      |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
interface iomem_uart_if;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, output addr, output wstrb, output wdata,
                  input rdata, input ready);
  modport slave  (input sel, input addr, input wstrb, input wdata,
                  output rdata, output ready);
endinterface
`default_nettype wire

// File: rtl/iomem_uart.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : iomem_uart                                              |
// | Description : Memory-mapped UART: TX shifter, RX shifter with a       |
// |               one-byte holding register and a programmable baud       |
// |               divider. Registers: 0=DATA 1=DIV 2=STATUS 3=reserved.   |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module iomem_uart #(
  parameter int DEFAULT_DIV = 208
) (
  input  logic         clk,
  input  logic         reset,
  iomem_uart_if.slave  bus,
  output logic         uart_tx,
  input  logic         uart_rx
);

  localparam logic [15:0] c_reset_div = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // Bus side
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] div_q, div_d;
  logic [31:0] rd_val;
  logic        is_write, is_data_wr, tx_free, accept, data_rd, tx_load, status_wr;

  // TX side
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;
  logic        tx_bit_end, tx_busy;

  // RX side
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic        rx_done_ok, rx_done_bad, rx_bit_end, rx_half_end;

  logic        unused_wdata;
  assign unused_wdata = ^bus.wdata[31:16];

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign uart_tx   = tx_line_q;
  assign tx_busy   = (tx_state_q != TX_IDLE);

  // A DATA write may complete on the last cycle of a stop bit so that the
  // next frame starts with no idle gap.
  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_free    = !tx_busy || ((tx_state_q == TX_STOP) && tx_bit_end);
  assign is_write   = |bus.wstrb;
  assign is_data_wr = (bus.addr == 2'd0) && bus.wstrb[0];
  assign accept     = bus.sel && !ready_q && !(is_data_wr && !tx_free);
  assign data_rd    = accept && !is_write && (bus.addr == 2'd0);
  assign tx_load    = accept && is_data_wr;
  assign status_wr  = accept && (bus.addr == 2'd2) && bus.wstrb[0];

  // Read-data multiplexer over the register map
  always_comb begin
    rd_val = 32'd0;
    case (bus.addr)
      2'd0:    rd_val = {23'd0, rx_valid_q, rx_byte_q};
      2'd1:    rd_val = {16'd0, div_q};
      2'd2:    rd_val = {28'd0, ferr_q, overrun_q, tx_busy, rx_valid_q};
      default: rd_val = 32'd0;
    endcase
  end

  // Bus acknowledge, read data capture and divider register
  always_comb begin
    ready_d = accept;
    rdata_d = (accept && !is_write) ? rd_val : 32'd0;
    div_d   = div_q;
    if (accept && is_write && (bus.addr == 2'd1)) begin
      div_d = (bus.wdata[15:0] < 16'd2) ? 16'd2 : bus.wdata[15:0];
    end
  end

  // TX framing: start, 8 data bits LSB first, stop; divider latched per frame
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_cnt_d   = 16'd0;
          tx_div_d   = div_q;
          tx_shift_d = bus.wdata[7:0];
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 4'd0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 4'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = 16'd0;
          if (tx_load) begin
            tx_state_d = TX_START;
            tx_div_d   = div_q;
            tx_shift_d = bus.wdata[7:0];
            tx_line_d  = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX framing: mid-bit sampling after a half-bit start recheck
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 16'd0;
          rx_div_d   = div_q;
        end
      end
      RX_START: begin
        if (rx_half_end) begin
          rx_cnt_d = 16'd0;
          rx_bit_d = 4'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 4'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d = 16'd0;
          if (rx_s2_q) begin
            rx_done_ok = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_done_bad = 1'b1;
            rx_state_d  = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_WAIT: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Holding register and sticky flags; a completing frame beats a same-cycle read clear
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;
    if (data_rd) rx_valid_d = 1'b0;
    if (status_wr) begin
      if (bus.wdata[3]) ferr_d    = 1'b0;
      if (bus.wdata[2]) overrun_d = 1'b0;
    end
    if (rx_done_ok) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !data_rd) overrun_d = 1'b1;
    end
    if (rx_done_bad) ferr_d = 1'b1;
  end

  // State registers with synchronous reset; RX pin passes a 2-flop synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      div_q      <= c_reset_div;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= c_reset_div;
      tx_bit_q   <= 4'd0;
      tx_shift_q <= 8'd0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= c_reset_div;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'd0;
      rx_byte_q  <= 8'd0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule
`default_nettype wire
